// File: rtl/fsm_step_ctrl.sv
// Debug/step controller: conditions raw buttons/switches into a clock-enable pulse and stable x for the FSM core.
// Latency: debounced step edge -> step_en in 2 cycles; run mode repeats every RUN_DIV+3 cycles.
// Backpressure: none; button edges outside PAUSE are ignored, except run, which requests a stop.

module fsm_step_db #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt;
    logic            level;
    logic            level_q;

    // The level flips only after DB_CYCLES back-to-back cycles of disagreement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level;
            if (sync_q[1] != level) begin
                if (cnt == DB_W'(DB_CYCLES - 1)) begin
                    level <= sync_q[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;
endmodule

module fsm_step_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int RUN_DIV   = 25000000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic [1:0]       sw_x,
    input  logic             brk_en,
    input  logic [3:0]       brk_state,
    input  logic [3:0]       state_in,
    output logic             step_en,
    output logic [1:0]       x_out,
    output logic             running,
    output logic             brk_hit,
    output logic [CNT_W-1:0] step_count,
    output logic [2:0]       ctrl_state
);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [2:0] {
        PAUSE = 3'd0,
        ARM   = 3'd1,
        FIRE  = 3'd2,
        CHECK = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic             run_mode, run_mode_n;
    logic             stop_req, stop_req_n;
    logic             brk_hit_q, brk_hit_n;
    logic [1:0]       x_q, x_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [1:0]       x_s1, x_s2;
    logic             step_edge;
    logic             run_edge;

    fsm_step_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_step),
        .rise  (step_edge)
    );

    fsm_step_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_run),
        .rise  (run_edge)
    );

    always_comb begin
        state_n    = state;
        run_mode_n = run_mode;
        stop_req_n = stop_req;
        brk_hit_n  = brk_hit_q;
        x_n        = x_q;
        cnt_n      = cnt_q;
        div_n      = div_q;
        case (state)
            PAUSE: begin
                if (run_edge || step_edge) begin
                    state_n    = ARM;
                    run_mode_n = run_edge;
                    brk_hit_n  = 1'b0;
                    stop_req_n = 1'b0;
                end
            end
            ARM: begin
                x_n     = x_s2;
                state_n = FIRE;
                if (run_edge) stop_req_n = 1'b1;
            end
            FIRE: begin
                if (cnt_q != '1) cnt_n = cnt_q + 1'b1;
                state_n = CHECK;
                if (run_edge) stop_req_n = 1'b1;
            end
            CHECK: begin
                // A stop request arriving in this very cycle still ends the run here.
                if (brk_en && state_in == brk_state) begin
                    state_n    = PAUSE;
                    brk_hit_n  = 1'b1;
                    run_mode_n = 1'b0;
                    stop_req_n = 1'b0;
                end else if (run_mode && !(stop_req || run_edge)) begin
                    state_n = WAIT;
                    div_n   = DIV_W'(RUN_DIV - 1);
                end else begin
                    state_n    = PAUSE;
                    run_mode_n = 1'b0;
                    stop_req_n = 1'b0;
                end
            end
            WAIT: begin
                if (run_edge) begin
                    state_n    = PAUSE;
                    run_mode_n = 1'b0;
                end else if (div_q == '0) begin
                    state_n = ARM;
                end else begin
                    div_n = div_q - 1'b1;
                end
            end
            default: begin
                state_n    = PAUSE;
                run_mode_n = 1'b0;
                stop_req_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PAUSE;
            run_mode  <= 1'b0;
            stop_req  <= 1'b0;
            brk_hit_q <= 1'b0;
            x_q       <= 2'b00;
            cnt_q     <= '0;
            div_q     <= '0;
            x_s1      <= 2'b00;
            x_s2      <= 2'b00;
        end else begin
            state     <= state_n;
            run_mode  <= run_mode_n;
            stop_req  <= stop_req_n;
            brk_hit_q <= brk_hit_n;
            x_q       <= x_n;
            cnt_q     <= cnt_n;
            div_q     <= div_n;
            x_s1      <= sw_x;
            x_s2      <= x_s1;
        end
    end

    assign step_en    = (state == FIRE);
    assign running    = run_mode;
    assign x_out      = x_q;
    assign brk_hit    = brk_hit_q;
    assign step_count = cnt_q;
    assign ctrl_state = state;
endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Bench for fsm_step_ctrl: models the FSM core as a step counter and scoreboards every step_en pulse.
module tb_fsm_step_ctrl;
    localparam int DB_CYCLES = 4;
    localparam int RUN_DIV   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_step, btn_run, brk_en;
    logic [1:0]  sw_x;
    logic [3:0]  brk_state;
    logic [3:0]  core_state;

    logic        step_en, running, brk_hit;
    logic [1:0]  x_out;
    logic [15:0] step_count;
    logic [2:0]  ctrl_state;

    logic        step_en2, running2, brk_hit2;
    logic [1:0]  x_out2;
    logic [1:0]  step_count2;
    logic [2:0]  ctrl_state2;

    typedef struct {
        logic [1:0]  x;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend_e;
    logic pend = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_steps = 0;
    int   pulse_cnt = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic run_prev = 1'b0;

    always #5 clk = ~clk;

    fsm_step_ctrl #(.DB_CYCLES(DB_CYCLES), .RUN_DIV(RUN_DIV), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run), .sw_x(sw_x),
        .brk_en(brk_en), .brk_state(brk_state), .state_in(core_state),
        .step_en(step_en), .x_out(x_out), .running(running), .brk_hit(brk_hit),
        .step_count(step_count), .ctrl_state(ctrl_state)
    );

    fsm_step_ctrl #(.DB_CYCLES(DB_CYCLES), .RUN_DIV(RUN_DIV), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run), .sw_x(sw_x),
        .brk_en(brk_en), .brk_state(brk_state), .state_in(core_state),
        .step_en(step_en2), .x_out(x_out2), .running(running2), .brk_hit(brk_hit2),
        .step_count(step_count2), .ctrl_state(ctrl_state2)
    );

    // FSM core stand-in: present state advances by one on every enabled clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) core_state <= 4'd0;
        else if (step_en) core_state <= core_state + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            chk("step_count", step_count, pend_e.cnt);
            chk("step_count_w2", step_count2, pend_e.cnt2);
            pend = 1'b0;
        end
        if (reset && step_en) begin
            pulse_cnt++;
            chk("step_en_w2", step_en2, 1);
            if (sb_q.size() == 0) begin
                chk("spurious_step", step_en, 1'b0);
            end else begin
                pend_e = sb_q.pop_front();
                pend   = 1'b1;
                chk("x_out", x_out, pend_e.x);
            end
            if (running) begin
                if (run_prev) chk("run_period", cyc - last_cyc, RUN_DIV + 3);
                run_prev = 1'b1;
                last_cyc = cyc;
            end
        end
        if (!running) run_prev = 1'b0;
    end

    task automatic push_step(input logic [1:0] x);
        exp_t e;
        n_steps++;
        e.x    = x;
        e.cnt  = 16'(n_steps);
        e.cnt2 = (n_steps > 3) ? 2'd3 : 2'(n_steps);
        sb_q.push_back(e);
    endtask

    task automatic press_step(input int hold);
        btn_step = 1'b1;
        repeat (hold) @(negedge clk);
        btn_step = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        while ((sb_q.size() != 0 || ctrl_state != 3'd0) && b < 300) begin
            @(negedge clk);
            b++;
        end
        repeat (12) @(negedge clk);
        chk({tag, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_steps = 0;
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int pc0;
        int b;
        logic [2:0] st_prev;
        reset = 1'b0; btn_step = 1'b0; btn_run = 1'b0; sw_x = 2'b00;
        brk_en = 1'b0; brk_state = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_step_en", step_en, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_running", running, 0);
        chk("rst_brk_hit", brk_hit, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_ctrl_state", ctrl_state, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Clean single step
        sw_x = 2'b10;
        push_step(2'b10);
        press_step(10);
        wait_idle("step1");
        chk("step1_count", step_count, 1);
        chk("step1_state", ctrl_state, 0);

        // Bouncing button: no pulse until it settles
        sw_x = 2'b01;
        pc0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            btn_step = 1'b1; repeat (2) @(negedge clk);
            btn_step = 1'b0; repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("bounce_no_pulse", pulse_cnt, pc0);
        push_step(2'b01);
        press_step(10);
        wait_idle("bounce");
        chk("bounce_one_pulse", pulse_cnt, pc0 + 1);

        // Free run, stopped by a second run press while waiting
        sw_x = 2'b11;
        pc0 = pulse_cnt;
        for (int i = 0; i < 3; i++) push_step(2'b11);
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        b = 0;
        while (pulse_cnt != pc0 + 2 && b < 100) begin @(negedge clk); b++; end
        chk("run_running", running, 1);
        repeat (3) @(negedge clk);
        btn_run = 1'b1;
        st_prev = ctrl_state;
        b = 0;
        while (running && b < 40) begin st_prev = ctrl_state; @(negedge clk); b++; end
        chk("stop_from_wait", st_prev, 3'd4);
        chk("stop_to_pause", ctrl_state, 3'd0);
        chk("stop_running", running, 0);
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        repeat (20) @(negedge clk);
        chk("run_drain", sb_q.size(), 0);
        chk("run_pulses", pulse_cnt, pc0 + 3);

        // Breakpoint on core state 3
        do_reset();
        sw_x = 2'b01; brk_en = 1'b1; brk_state = 4'd3;
        pc0 = pulse_cnt;
        for (int i = 0; i < 3; i++) push_step(2'b01);
        btn_run = 1'b1;
        repeat (8) @(negedge clk);
        btn_run = 1'b0;
        b = 0;
        while (!(pulse_cnt == pc0 + 3 && ctrl_state == 3'd0) && b < 200) begin @(negedge clk); b++; end
        repeat (10) @(negedge clk);
        chk("brk_hit_set", brk_hit, 1);
        chk("brk_running", running, 0);
        chk("brk_count", step_count, 3);
        chk("brk_core", core_state, 3);
        chk("brk_pulses", pulse_cnt, pc0 + 3);
        push_step(2'b01);
        press_step(8);
        wait_idle("brk_step");
        chk("brk_hit_clr", brk_hit, 0);
        chk("brk_step_count", step_count, 4);
        brk_en = 1'b0;

        // Reset asserted in FIRE during a run
        btn_run = 1'b1;
        b = 0;
        do begin @(posedge clk); #1; b++; end while (ctrl_state != 3'd2 && b < 50);
        chk("pre_rst_x_out", x_out, 2'b01);
        reset = 1'b0;
        btn_run = 1'b0;
        #1;
        chk("mid_rst_step_en", step_en, 0);
        chk("mid_rst_x_out", x_out, 0);
        chk("mid_rst_count", step_count, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_state", ctrl_state, 0);
        pc0 = pulse_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_steps = 0;
        repeat (15) @(negedge clk);
        chk("post_rst_state", ctrl_state, 0);
        chk("post_rst_pulses", pulse_cnt, pc0);

        // Five single steps: narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            logic [1:0] xv;
            xv = 2'(i);
            sw_x = xv;
            push_step(xv);
            press_step(8);
            wait_idle("sat");
        end
        chk("sat_count16", step_count, 5);
        chk("sat_count2", step_count2, 3);
        chk("sat_state_w2", ctrl_state2, 0);
        chk("sat_running_w2", running2, 0);
        chk("sat_brk_w2", brk_hit2, 0);
        chk("sat_x_w2", x_out2, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
